// File: rtl/lw_sha_pkg.sv
// lw_sha_pkg: shared types and constants for the SHA-2 message padder.
package lw_sha_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PACK,
        ST_PAD,
        ST_LEN
    } pad_state_t;

    localparam logic [7:0] PAD_BYTE     = 8'h80;
    localparam logic [3:0] LEN_WORD_IDX = 4'd14;

    // 16 words of word_w/8 bytes each.
    function automatic int unsigned blk_bytes(input int unsigned word_w);
        return 2 * word_w;
    endfunction

endpackage

// File: rtl/lw_sha_byte_packer.sv
// lw_sha_byte_packer: big-endian byte-to-word assembly with 0x80 insertion after the last byte.
module lw_sha_byte_packer
    import lw_sha_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clr,
    input  logic              i_byte_vld,
    input  logic [7:0]        i_byte,
    input  logic              i_last,
    input  logic              i_empty,
    input  logic              i_pad_take,
    output logic              o_off_full,
    output logic              o_word_done,
    output logic [WORD_W-1:0] o_word,
    output logic              o_pad_pend,
    output logic [WORD_W-1:0] o_pad_word
);
    localparam int NB = WORD_W / 8;
    localparam int OW = $clog2(NB);
    localparam logic [WORD_W-1:0] PAD_WORD = {PAD_BYTE, {(WORD_W-8){1'b0}}};

    logic [OW-1:0]     r_off;
    logic [WORD_W-1:0] r_acc;
    logic              r_pend;
    logic [WORD_W-1:0] w_fill;
    int                w_sh;

    assign o_off_full  = (r_off == OW'(NB - 1));
    assign o_word_done = i_byte_vld && o_off_full;
    assign o_word      = w_fill;
    assign o_pad_pend  = r_pend;
    assign o_pad_word  = r_acc;

    always_comb begin
        w_sh   = 8 * (NB - 1 - int'(r_off));
        w_fill = r_acc;
        w_fill[w_sh +: 8] = i_byte;
        // Bytes past the write pointer are already zero; only the marker is added.
        if (i_last && !o_off_full)
            w_fill[w_sh - 8 +: 8] = PAD_BYTE;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_off  <= '0;
            r_acc  <= '0;
            r_pend <= 1'b0;
        end else if (i_clr) begin
            r_off  <= '0;
            r_acc  <= '0;
            r_pend <= 1'b0;
        end else if (i_empty) begin
            r_off  <= '0;
            r_acc  <= PAD_WORD;
            r_pend <= 1'b1;
        end else if (i_byte_vld) begin
            r_pend <= i_last;
            if (o_off_full) begin
                r_off <= '0;
                r_acc <= i_last ? PAD_WORD : '0;
            end else begin
                r_off <= r_off + OW'(1);
                r_acc <= w_fill;
            end
        end else if (i_pad_take) begin
            r_off  <= '0;
            r_acc  <= '0;
            r_pend <= 1'b0;
        end
    end

endmodule

// File: rtl/lw_sha_padder.sv
// lw_sha_padder: byte stream to SHA-2 padded word stream for the hash/HMAC engine.
// Define LW_PAD_HMAC_EN to add hmac_i, which counts one key block into the length field.
module lw_sha_padder
    import lw_sha_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic              clk_i,
    input  logic              aresetn_i,
    input  logic              abort_i,
    input  logic [7:0]        in_data_i,
    input  logic              in_valid_i,
    input  logic              in_last_i,
    output logic              in_ready_o,
    input  logic              msg_empty_i,
`ifdef LW_PAD_HMAC_EN
    input  logic              hmac_i,
`endif
    output logic              start_o,
    output logic [WORD_W-1:0] data_o,
    output logic              data_valid_o,
    output logic              last_o,
    input  logic              ready_i,
    output logic              busy_o
);
    localparam int LW = 2 * WORD_W;

    pad_state_t        r_state;
    logic              r_run, r_vld, r_start, r_last, r_first;
    logic [WORD_W-1:0] r_data;
    logic [3:0]        r_widx;
    logic [60:0]       r_bytes;
`ifdef LW_PAD_HMAC_EN
    logic              r_hmac;
`endif

    logic              w_xfer, w_free, w_acc, w_empty;
    logic              w_load, w_load_last, w_pad_take;
    logic              w_off_full, w_word_done, w_pad_pend;
    logic [WORD_W-1:0] w_pack_word, w_pad_word, w_load_word;
    logic [63:0]       w_len_bits;
    logic [LW-1:0]     w_len_field;

    assign w_xfer  = r_vld && ready_i;
    assign w_free  = !r_vld || w_xfer;
    assign in_ready_o = r_run && !abort_i && (r_state == ST_IDLE || r_state == ST_PACK)
                        && !(w_off_full && r_vld && !w_xfer);
    assign w_acc   = in_valid_i && in_ready_o;
    assign w_empty = r_run && !abort_i && (r_state == ST_IDLE) && msg_empty_i && !w_acc;

    assign start_o      = r_start;
    assign data_o       = r_data;
    assign data_valid_o = r_vld;
    assign last_o       = r_last;
    assign busy_o       = (r_state != ST_IDLE);

    lw_sha_byte_packer #(.WORD_W(WORD_W)) u_packer (
        .i_clk       (clk_i),
        .i_rst_n     (aresetn_i),
        .i_clr       (abort_i),
        .i_byte_vld  (w_acc),
        .i_byte      (in_data_i),
        .i_last      (in_last_i),
        .i_empty     (w_empty),
        .i_pad_take  (w_pad_take),
        .o_off_full  (w_off_full),
        .o_word_done (w_word_done),
        .o_word      (w_pack_word),
        .o_pad_pend  (w_pad_pend),
        .o_pad_word  (w_pad_word)
    );

    always_comb begin
        w_len_bits = {r_bytes, 3'b000};
`ifdef LW_PAD_HMAC_EN
        if (r_hmac)
            w_len_bits = w_len_bits + 64'(8 * blk_bytes(WORD_W));
`endif
    end
    assign w_len_field = LW'(w_len_bits);

    // r_widx is the block index of the next word loaded into the output register.
    always_comb begin
        w_load      = 1'b0;
        w_load_word = '0;
        w_load_last = 1'b0;
        w_pad_take  = 1'b0;
        case (r_state)
            ST_IDLE, ST_PACK: begin
                w_load      = w_word_done;
                w_load_word = w_pack_word;
            end
            ST_PAD: begin
                w_load = w_free;
                if (w_pad_pend) begin
                    w_load_word = w_pad_word;
                    w_pad_take  = w_free;
                end
            end
            ST_LEN: begin
                if (r_widx == LEN_WORD_IDX) begin
                    w_load      = w_free;
                    w_load_word = w_len_field[LW-1:WORD_W];
                end else if (r_widx == LEN_WORD_IDX + 4'd1) begin
                    w_load      = w_free;
                    w_load_word = w_len_field[WORD_W-1:0];
                    w_load_last = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            r_state <= ST_IDLE;
            r_run   <= 1'b0;
            r_vld   <= 1'b0;
            r_start <= 1'b0;
            r_last  <= 1'b0;
            r_first <= 1'b0;
            r_data  <= '0;
            r_widx  <= '0;
            r_bytes <= '0;
`ifdef LW_PAD_HMAC_EN
            r_hmac  <= 1'b0;
`endif
        end else if (abort_i) begin
            r_state <= ST_IDLE;
            r_vld   <= 1'b0;
            r_start <= 1'b0;
            r_last  <= 1'b0;
            r_first <= 1'b0;
            r_data  <= '0;
            r_widx  <= '0;
            r_bytes <= '0;
`ifdef LW_PAD_HMAC_EN
            r_hmac  <= 1'b0;
`endif
        end else begin
            r_run <= 1'b1;
            if (w_load) begin
                r_data  <= w_load_word;
                r_vld   <= 1'b1;
                r_start <= r_first;
                r_last  <= w_load_last;
                r_first <= 1'b0;
                r_widx  <= r_widx + 4'd1;
            end else if (w_xfer) begin
                r_vld   <= 1'b0;
                r_start <= 1'b0;
                r_last  <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_acc || w_empty) begin
                        r_bytes <= w_acc ? 61'd1 : 61'd0;
                        r_widx  <= '0;
                        r_first <= 1'b1;
`ifdef LW_PAD_HMAC_EN
                        r_hmac  <= hmac_i;
`endif
                        r_state <= (w_acc && !in_last_i) ? ST_PACK : ST_PAD;
                    end
                end
                ST_PACK: begin
                    if (w_acc) begin
                        r_bytes <= r_bytes + 61'd1;
                        if (in_last_i)
                            r_state <= ST_PAD;
                    end
                end
                ST_PAD: begin
                    if (w_load && r_widx == LEN_WORD_IDX - 4'd1)
                        r_state <= ST_LEN;
                end
                ST_LEN: begin
                    if (w_xfer && r_last)
                        r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lw_sha_padder.sv
// tb_lw_sha_padder: directed-vector bench for lw_sha_padder at WORD_W=32 and WORD_W=64.
module tb_lw_sha_padder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        abort = 1'b0;
    logic        tb_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        msg_empty = 1'b0;
    logic        sel64 = 1'b0;
    logic        tb_ready = 1'b1;
    logic        bp_en = 1'b0;
    logic        hold_en = 1'b0;
    logic [7:0]  in_data = 8'h00;
`ifdef LW_PAD_HMAC_EN
    logic        hmac = 1'b0;
`endif
    logic [15:0] lfsr = 16'hACE1;
    logic        rdy_i;
    logic        rdy32, st32, dv32, ls32, bz32;
    logic        rdy64, st64, dv64, ls64, bz64;
    logic [31:0] d32;
    logic [63:0] d64;
    logic [65:0] q32[$];
    logic [65:0] q64[$];
    logic [63:0] ex[64];
    logic [7:0]  msg[128];
    logic        hold_v = 1'b0;
    logic [34:0] hold_val = '0;
    logic        saw_block = 1'b0;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    assign rdy_i = bp_en ? (lfsr[0] & lfsr[3]) : tb_ready;

    lw_sha_padder #(.WORD_W(32)) u_dut32 (
        .clk_i(clk), .aresetn_i(rst_n), .abort_i(abort),
        .in_data_i(in_data), .in_valid_i(tb_valid & ~sel64), .in_last_i(in_last),
        .in_ready_o(rdy32), .msg_empty_i(msg_empty & ~sel64),
`ifdef LW_PAD_HMAC_EN
        .hmac_i(hmac),
`endif
        .start_o(st32), .data_o(d32), .data_valid_o(dv32), .last_o(ls32),
        .ready_i(rdy_i), .busy_o(bz32)
    );

    lw_sha_padder #(.WORD_W(64)) u_dut64 (
        .clk_i(clk), .aresetn_i(rst_n), .abort_i(abort),
        .in_data_i(in_data), .in_valid_i(tb_valid & sel64), .in_last_i(in_last),
        .in_ready_o(rdy64), .msg_empty_i(msg_empty & sel64),
`ifdef LW_PAD_HMAC_EN
        .hmac_i(hmac),
`endif
        .start_o(st64), .data_o(d64), .data_valid_o(dv64), .last_o(ls64),
        .ready_i(rdy_i), .busy_o(bz64)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Word capture and stall-stability checks, sampled mid-cycle.
    always @(negedge clk) begin
        if (dv32 && rdy_i) q32.push_back({st32, ls32, 32'h0, d32});
        if (dv64 && rdy_i) q64.push_back({st64, ls64, d64});
        if (hold_v) chk("stall_hold", {dv32, d32, st32, ls32}, hold_val);
        hold_v   <= hold_en && dv32 && !rdy_i;
        hold_val <= {1'b1, d32, st32, ls32};
        if (hold_en && dv32 && !rdy32 && tb_valid) saw_block <= 1'b1;
    end

    task automatic send_byte(input logic [7:0] b, input logic last);
        logic took;
        in_data  = b;
        in_last  = last;
        tb_valid = 1'b1;
        took     = 1'b0;
        for (int c = 0; c < 500 && !took; c++) begin
            @(negedge clk);
            took = sel64 ? rdy64 : rdy32;
            @(posedge clk);
            #1;
        end
        tb_valid = 1'b0;
        in_last  = 1'b0;
        chk("byte_accept", took, 1'b1);
    endtask

    task automatic send_msg(input int n, input logic with_last);
        for (int i = 0; i < n; i++) send_byte(msg[i], with_last && (i == n - 1));
    endtask

    task automatic wait_msg(input logic sel, input int n);
        int sz;
        for (int c = 0; c < 4000; c++) begin
            sz = sel ? q64.size() : q32.size();
            if (sz >= n && !(sel ? bz64 : bz32)) break;
            @(posedge clk);
            #1;
        end
        chk("msg_idle", sel ? bz64 : bz32, 1'b0);
    endtask

    task automatic chk_msg(input string tag, input logic sel, input int n);
        logic [65:0] e;
        int sz;
        sz = sel ? q64.size() : q32.size();
        chk({tag, "_count"}, sz, n);
        for (int i = 0; i < n && i < sz; i++) begin
            e = sel ? q64[i] : q32[i];
            chk($sformatf("%s_w%0d", tag, i), e[63:0], ex[i]);
            chk($sformatf("%s_start%0d", tag, i), e[65], (i == 0));
            chk($sformatf("%s_last%0d", tag, i), e[64], (i == n - 1));
        end
    endtask

    task automatic clr_ex();
        for (int i = 0; i < 64; i++) ex[i] = '0;
    endtask

    task automatic set_abc();
        msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    endtask

    initial begin
        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", rdy32, 1'b0);
        chk("rst_valid", dv32, 1'b0);
        chk("rst_start", st32, 1'b0);
        chk("rst_last", ls32, 1'b0);
        chk("rst_busy", bz32, 1'b0);
        chk("rst_data", d32, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_in_ready", rdy32, 1'b1);

        // "abc", 32-bit
        q32.delete(); set_abc(); send_msg(3, 1'b1); wait_msg(1'b0, 16);
        clr_ex(); ex[0] = 64'h61626380; ex[15] = 64'h18;
        chk_msg("abc32", 1'b0, 16);

        // Zero-length message
        q32.delete();
        msg_empty = 1'b1; @(posedge clk); #1; msg_empty = 1'b0;
        wait_msg(1'b0, 16);
        clr_ex(); ex[0] = 64'h80000000;
        chk_msg("empty32", 1'b0, 16);

        // 56 zero bytes: marker lands at index 14, rolls into a second block
        q32.delete();
        for (int i = 0; i < 56; i++) msg[i] = 8'h00;
        send_msg(56, 1'b1); wait_msg(1'b0, 32);
        clr_ex(); ex[14] = 64'h80000000; ex[31] = 64'h1C0;
        chk_msg("z56", 1'b0, 32);

        // "abc", 64-bit
        sel64 = 1'b1; q64.delete(); set_abc(); send_msg(3, 1'b1); wait_msg(1'b1, 16);
        clr_ex(); ex[0] = 64'h6162638000000000; ex[15] = 64'h18;
        chk_msg("abc64", 1'b1, 16);
        sel64 = 1'b0;

`ifdef LW_PAD_HMAC_EN
        // HMAC "abc": length includes one 64-byte key block
        hmac = 1'b1; q32.delete(); set_abc(); send_msg(3, 1'b1); hmac = 1'b0;
        wait_msg(1'b0, 16);
        clr_ex(); ex[0] = 64'h61626380; ex[15] = 64'h218;
        chk_msg("hmac32", 1'b0, 16);
`endif

        // 100 bytes under random backpressure
        q32.delete(); clr_ex();
        for (int i = 0; i < 100; i++) msg[i] = 8'(i * 7 + 3);
        for (int k = 0; k < 25; k++) ex[k] = {32'h0, msg[4*k], msg[4*k+1], msg[4*k+2], msg[4*k+3]};
        ex[25] = 64'h80000000; ex[31] = 64'h320;
        hold_en = 1'b1; bp_en = 1'b1;
        send_msg(100, 1'b1); wait_msg(1'b0, 32);
        bp_en = 1'b0; @(posedge clk); #1; hold_en = 1'b0;
        chk_msg("bp100", 1'b0, 32);
        chk("bp_in_ready_drop", saw_block, 1'b1);

        // Abort after 5 bytes with a word held in the output register
        q32.delete(); tb_ready = 1'b0;
        for (int i = 0; i < 5; i++) msg[i] = 8'h41 + 8'(i);
        send_msg(5, 1'b0);
        @(negedge clk);
        chk("abort_pre_valid", dv32, 1'b1);
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        chk("abort_valid", dv32, 1'b0);
        chk("abort_busy", bz32, 1'b0);
        tb_ready = 1'b1;
        @(posedge clk); #1;
        q32.delete(); set_abc(); send_msg(3, 1'b1); wait_msg(1'b0, 16);
        clr_ex(); ex[0] = 64'h61626380; ex[15] = 64'h18;
        chk_msg("post_abort", 1'b0, 16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lw_sha_padder.md
# lw_sha_padder

Upstream feeder for `lw_hmac`. It takes a raw byte stream and packs it big-endian into `WORD_W`-bit words. It appends SHA-2 padding (a 0x80 byte, zero fill and a 2·`WORD_W`-bit bit-length field) and drives the hash/HMAC engine's `start_i`/`data_valid_i`/`last_i`/`data_i` inputs, obeying its `ready_o` backpressure. In HMAC mode the length field includes the one-block key prefix that the engine inserts.

## Interface
- `WORD_W`, default 32: datapath word width; 32 selects the SHA-224/256 block, 64 selects the SHA-384/512 block. Block = 16 words.
- `clk_i`  in  1  clock.
- `aresetn_i`  in  1  asynchronous, active-low reset.
- `abort_i`  in  1  drop the current message; return to IDLE next cycle.
- `in_data_i`  in  8  message byte.
- `in_valid_i`  in  1  byte valid.
- `in_last_i`  in  1  final byte of the message; qualified by `in_valid_i`.
- `in_ready_o`  out  1  byte accepted when `in_valid_i && in_ready_o`.
- `msg_empty_i`  in  1  IDLE-only pulse requesting a zero-length message.
- `hmac_i`  in  1  sampled on the first accepted byte or on `msg_empty_i`; present only with `LW_PAD_HMAC_EN`.
- `start_o`  out  1  high together with `data_valid_o` on the first word of a message.
- `data_o`  out  `WORD_W`  packed or padding word.
- `data_valid_o`  out  1  `data_o` valid.
- `last_o`  out  1  high on the final length word.
- `ready_i`  in  1  engine `ready_o`; a word transfers when `data_valid_o && ready_i`.
- `busy_o`  out  1  state ≠ IDLE.

## Operation
- **States:** IDLE, PACK, PAD, LEN.
- **IDLE:**
  - On the first accepted byte, clear the counters and go to PACK.
  - On `msg_empty_i`, go to PAD with a pending 0x80 byte at offset 0.
- **PACK:**
  - Bytes fill a pack register MSB-first.
  - A full word moves to a single output register (`out_full`).
  - On `in_last_i`, place 0x80 in the next free byte of the current word and zero the rest, then go to PAD. If the last byte fills the word, 0x80 starts the next word.
- **PAD:**
  - Emit the word holding 0x80, if still pending.
  - Then emit zero words until the word index in the block equals 14, then go to LEN.
  - If the 0x80 word lands at index 14 or 15, zero-fill to 15. The next block starts with zeros and reaches index 14.
- **LEN:**
  - Word 14 = upper `WORD_W` bits of the length field; word 15 = lower bits, with `last_o`.
  - After word 15 transfers, go to IDLE.
- **Length field:**
  - Length = 8·(message bytes), plus 8·(block bytes) when `hmac_i` is latched. Block bytes = 2·`WORD_W`.
  - Byte counter is 61 bits and wraps silently.
  - With `WORD_W`=64, word 14 is zero-extended.
- **Word index:** 4 bits, wraps 15→0 on transfer. It counts every emitted word, including data words.
- **`start_o`:** high only while the first word of the message is held and until it transfers.
- **`abort_i`:** highest priority in any state.
  - Next cycle: clear `out_full`, counters and flags; state IDLE.
  - No further `data_valid_o`.
- A simultaneous word transfer and new byte in the same cycle are both taken.

## Timing
- **Reset values:** `in_ready_o`=0 while reset is asserted; `start_o`, `data_valid_o`, `last_o`, `busy_o`=0; `data_o`=0; state IDLE.
- **Byte acceptance:** `in_ready_o` = (IDLE or PACK) && !(word would complete && `out_full` && !(`data_valid_o` && `ready_i`)). Up to one byte per cycle.
- **Word latency:** a word completed at edge N shows `data_valid_o` from edge N (registered), visible in cycle N+1.
- **Padding rate:** padding and length words issue back-to-back, one per cycle while `ready_i`=1.
- **Output hold:** `data_o`, `start_o`, `last_o` stay stable while `data_valid_o && !ready_i`.
- **Minimum length:** a 1-byte message takes 16 output words, or 32 when padding rolls over into a second block.

## Configuration
- **`LW_PAD_HMAC_EN` defined:** port `hmac_i` exists, is latched per message, and adds one block to the length field.
- **`LW_PAD_HMAC_EN` undefined:** no `hmac_i` port; the length field is the pure message length. Supports SHA-only builds.

## Structure
- **In `lw_sha_pkg`:**
  - Padder state enum.
  - Constant `PAD_BYTE` = 8'h80.
  - Constant `LEN_WORD_IDX` = 14.
  - Function returning block bytes for a given word width.
- **Sub-module `lw_sha_byte_packer`:**
  - Byte→word shift register with byte offset and `word_done`.
  - 0x80 insertion on the last byte.
  - Instantiated once.
- The top level holds the FSM, counters and output register.

## Test plan
- **"abc", WORD_W=32:** words 0x61626380, then 13× zero, then 0x00000000, 0x00000018. `last_o` on word 16; `start_o` on word 1 only.
- **56-byte message of 0x00, WORD_W=32:**
  - Words 0–13 zero.
  - Word 14 = 0x80000000, word 15 zero.
  - Second block: 14 zeros, then 0x00000000, 0x000001C0, with `last_o`.
- **HMAC "abc", WORD_W=32, `LW_PAD_HMAC_EN`:** length word 15 = 0x00000218.
- **"abc", WORD_W=64:** word 0 = 0x6162638000000000; word 14 = 0; word 15 = 0x18.
- **Backpressure:** `ready_i` toggled randomly during a 100-byte message. No word lost or duplicated; `data_o` stable while stalled; `in_ready_o` drops while `out_full`.
- **Abort after 5 bytes:** `data_valid_o`=0 the next cycle; `busy_o`=0; a following "abc" reproduces scenario 1 exactly.
